sram_rd_ctrl: RTL and testbench
===============================

SRAM_RD_CTRL -- requirements
Module: sram_rd_ctrl

Interface
REQ-001 SHALL have parameter width, default 512: SRAM data width in bits.
REQ-002 SHALL have parameter logDepth, default 7: SRAM address width.
REQ-003 SHALL have parameter latency, default 1, legal range 1..8: SRAM cycles from address sampled to readData valid.
REQ-004 SHALL have parameter fifoDepth, default 4, power of two, legal range 2..16: response buffer entries.
REQ-005 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  read request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle if req_valid.
REQ-009 SHALL have port req_addr  input  logDepth  read address.
REQ-010 SHALL have port sram_readAddr  output  logDepth  to SRAM readAddr.
REQ-011 SHALL have port sram_readData  input  width  from SRAM readData.
REQ-012 SHALL have port rsp_valid  output  1  response data available.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-014 SHALL have port rsp_data  output  width  response data.

Function
REQ-015 SHALL drive sram_readAddr = req_addr combinationally every cycle; a read is issued only on accept (req_valid && req_ready).
REQ-016 SHALL track issued reads in a latency-stage valid shift register; stage latency-1 set means sram_readData is valid this cycle.
REQ-017 SHALL write sram_readData into the FIFO on the cycle its valid bit reaches the last stage, with no bypass: response for a read accepted in cycle t is visible at rsp_valid no earlier than cycle t+latency+1.
REQ-018 SHALL keep a credit counter cnt (width clog2(fifoDepth+1)) = in-flight reads + FIFO occupancy; +1 on accept, -1 on pop (rsp_valid && rsp_ready), unchanged when both occur in the same cycle.
REQ-019 SHALL drive req_ready = (cnt < fifoDepth) from registered state only; it SHALL NOT depend combinationally on req_valid or rsp_ready.
REQ-020 SHALL, at cnt == fifoDepth with a pop in the same cycle, hold req_ready low that cycle and raise it the next cycle.
REQ-021 SHALL guarantee that a FIFO write never occurs when full; the credit rule makes overflow impossible.
REQ-022 SHALL return responses strictly in request order, one per accepted request, none dropped or duplicated.
REQ-023 SHALL drive rsp_valid = FIFO non-empty and rsp_data = FIFO head; rsp_data SHALL stay stable while rsp_valid && !rsp_ready.
REQ-024 SHALL handle simultaneous FIFO write and pop, including at occupancy 1 and at occupancy fifoDepth, without loss.
REQ-025 SHALL use read/write pointers of clog2(fifoDepth) bits that wrap modulo fifoDepth.
REQ-026 SHALL hold all outputs stable when no accept and no pop occur; rsp_valid SHALL drop only on pop of the last entry.

Reset
REQ-027 SHALL on reset assertion immediately clear cnt, all valid-pipe bits and both FIFO pointers, giving rsp_valid=0 and req_ready=1; rsp_data SHALL be don't-care.
REQ-028 SHALL discard reads in flight when reset asserts; SRAM data returning after reset release SHALL NOT be written into the FIFO.
REQ-029 SHALL accept a request in the first clock edge after reset deassertion.

Verification
REQ-030 SHALL cover single read: latency=1, mem[5]=0xA5 in all words, req at cycle t, rsp_ready=1 -> rsp_valid=1 at t+2 with rsp_data=0xA5 pattern, rsp_valid=0 at t+3.
REQ-031 SHALL cover backpressure: fifoDepth=4, rsp_ready=0, five back-to-back requests for addresses 0..4 -> four accepted and req_ready=0 after the 4th; address 4 accepted only after the first pop; data returned in order 0,1,2,3,4.
REQ-032 SHALL cover simultaneous pop and request at cnt=4 -> req_ready=0 that cycle, cnt=3 next cycle, req_ready=1 next cycle, next request accepted.
REQ-033 SHALL cover reset mid-operation: two reads in flight plus one buffered, reset pulsed -> rsp_valid=0 and req_ready=1 immediately; no response after release until a new request is issued.
REQ-034 SHALL cover random traffic: 1000 random-address requests with random req_valid and rsp_ready (50%), latency in {1,3} -> scoreboard matches a reference memory model, zero overflow assertions, cnt never exceeds fifoDepth.

Source files
------------

// File: rtl/sram_rd_ctrl.sv
// sram_rd_ctrl
//   Read controller for a fixed-latency SRAM. Requests are issued straight to
//   the SRAM address port. The controller then tracks each issued read through
//   a valid pipe and captures the returning word into a small response FIFO.
//   A credit counter covers every read that is in flight or buffered. Because
//   the counter gates req_ready, the FIFO can never overflow.
//
// Parameters
//   width     : SRAM data width in bits
//   logDepth  : SRAM address width
//   latency   : cycles from address sampled to sram_readData valid (1..8)
//   fifoDepth : response buffer entries, power of two (2..16)
//
// Ports
//   clk, reset     : single clock, asynchronous active-high reset
//   req_valid/ready: read request handshake; req_addr is the read address
//   sram_readAddr  : address to the SRAM (follows req_addr combinationally)
//   sram_readData  : data returned by the SRAM
//   rsp_valid/ready: response handshake; rsp_data is the FIFO head
module sram_rd_ctrl #(
  parameter int unsigned width     = 512,
  parameter int unsigned logDepth  = 7,
  parameter int unsigned latency   = 1,
  parameter int unsigned fifoDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [logDepth-1:0] req_addr,
  output logic [logDepth-1:0] sram_readAddr,
  input  logic [width-1:0]    sram_readData,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [width-1:0]    rsp_data
);

  localparam int unsigned CntW = $clog2(fifoDepth + 1);
  localparam int unsigned PtrW = $clog2(fifoDepth);
  localparam logic [CntW-1:0] CntMax = CntW'(fifoDepth);

  logic [latency-1:0] vpipe_q, vpipe_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    occ_q, occ_d;
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [width-1:0]   mem_q [fifoDepth];

  logic accept;
  logic pop;
  logic wr_en;

  assign sram_readAddr = req_addr;
  // Credits are counted from registered state only. A pop in the same cycle
  // cannot raise req_ready until the following cycle.
  assign req_ready     = (cnt_q < CntMax);
  assign rsp_valid     = (occ_q != '0);
  assign rsp_data      = mem_q[rptr_q];

  assign accept = req_valid && req_ready;
  assign pop    = rsp_valid && rsp_ready;
  // The top stage of the valid pipe marks sram_readData as valid this cycle.
  assign wr_en  = vpipe_q[latency-1];

  always_comb begin
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = accept;

    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    occ_d = occ_q;
    unique case ({wr_en, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase

    wptr_d = wr_en ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop   ? rptr_q + PtrW'(1) : rptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe_q <= '0;
      cnt_q   <= '0;
      occ_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      vpipe_q <= vpipe_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= sram_readData;
    end
  end

endmodule

// File: tb/tb_sram_rd_ctrl.sv
// tb_sram_rd_ctrl
//   Two controllers (latency 1 and latency 3) share one stimulus stream. Each
//   controller has a behavioural SRAM and a queue-based reference model.
//   The model records every accepted request with its accept time and memory
//   word. A response may appear exactly latency+1 cycles after its accept, in
//   order. Ready is required whenever fewer than fifoDepth requests are
//   outstanding.
module tb_sram_rd_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [511:0] d;
    int           t;
  } ent_t;

  typedef struct {
    bit         rst;
    bit         rv;
    logic [6:0] a;
    bit         rr;
    bit         e_rdy;
    bit         e_val;
    int         e_idx;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rv = 1'b0;
  logic [6:0]   ra = '0;
  logic         rr = 1'b0;

  logic         rdy [2];
  logic         val [2];
  logic [511:0] dat [2];
  logic [6:0]   sra [2];
  logic [511:0] srd [2];

  logic [511:0] mem [128];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, got, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 1 : 3;

    logic [7*L-1:0] aps;
    ent_t           q[$];
    int             acc = 0;
    int             qsz = 0;
    bit             exp_v;

    sram_rd_ctrl #(
      .width    (512),
      .logDepth (7),
      .latency  (L),
      .fifoDepth(DEPTH)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (rv),
      .req_ready    (rdy[g]),
      .req_addr     (ra),
      .sram_readAddr(sra[g]),
      .sram_readData(srd[g]),
      .rsp_valid    (val[g]),
      .rsp_ready    (rr),
      .rsp_data     (dat[g])
    );

    // SRAM: data for the address sampled at an edge is valid L cycles later.
    always @(posedge clk) aps <= (7*L)'({aps, sra[g]});
    assign srd[g] = mem[aps[7*L-1 -: 7]];

    always @(negedge clk) begin
      if (reset) begin
        q.delete();
        chkb("reset_ready", rdy[g], 1'b1);
        chkb("reset_valid", val[g], 1'b0);
      end else begin
        exp_v = (q.size() > 0) && (q[0].t + L + 1 <= cyc);
        chkb("model_ready", rdy[g], q.size() < DEPTH);
        chkb("model_valid", val[g], exp_v);
        if (exp_v) chkd("model_data", dat[g], q[0].d);
        if (val[g] && rr && q.size() > 0) void'(q.pop_front());
        if (rv && rdy[g]) begin
          q.push_back('{mem[ra], cyc});
          acc++;
        end
      end
      qsz = q.size();
    end
  end

  vec_t vecs[16];

  initial begin
    int a0, a1, n;

    for (int i = 0; i < 128; i++)
      for (int w = 0; w < 16; w++) mem[i][w*32 +: 32] = $urandom;
    mem[5] = {64{8'hA5}};

    // Single read, then a back-to-back burst that fills the buffer.
    vecs[0]  = '{1, 1, 7'd5, 1, 1, 0, -1};
    vecs[1]  = '{0, 0, 7'd0, 1, 1, 0, -1};
    vecs[2]  = '{0, 0, 7'd0, 1, 1, 1,  5};
    vecs[3]  = '{0, 0, 7'd0, 1, 1, 0, -1};
    vecs[4]  = '{1, 1, 7'd0, 0, 1, 0, -1};
    vecs[5]  = '{0, 1, 7'd1, 0, 1, 0, -1};
    vecs[6]  = '{0, 1, 7'd2, 0, 1, 1,  0};
    vecs[7]  = '{0, 1, 7'd3, 0, 1, 1,  0};
    vecs[8]  = '{0, 1, 7'd4, 0, 0, 1,  0};
    vecs[9]  = '{0, 1, 7'd4, 1, 0, 1,  0};
    vecs[10] = '{0, 1, 7'd4, 0, 1, 1,  1};
    vecs[11] = '{0, 0, 7'd0, 1, 0, 1,  1};
    vecs[12] = '{0, 0, 7'd0, 1, 1, 1,  2};
    vecs[13] = '{0, 0, 7'd0, 1, 1, 1,  3};
    vecs[14] = '{0, 0, 7'd0, 1, 1, 1,  4};
    vecs[15] = '{0, 0, 7'd0, 1, 1, 0, -1};

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) begin
        reset = 1'b1; rv = 1'b0; rr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
      end
      rv = vecs[i].rv; ra = vecs[i].a; rr = vecs[i].rr;
      @(negedge clk);
      chkb("vec_ready", rdy[0], vecs[i].e_rdy);
      chkb("vec_valid", val[0], vecs[i].e_val);
      if (vecs[i].e_idx >= 0) chkd("vec_data", dat[0], mem[vecs[i].e_idx]);
      @(posedge clk); #1;
    end
    chkd("single_read_pattern", mem[5], {64{8'hA5}});

    // Reset while reads are in flight and buffered.
    rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv = 1'b1; ra = 7'(10 + i);
      @(posedge clk); #1;
    end
    rv = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chkb("midrst_ready", rdy[g], 1'b1);
      chkb("midrst_valid", val[g], 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0; rr = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chkb("post_rst_idle0", val[0], 1'b0);
      chkb("post_rst_idle1", val[1], 1'b0);
      @(posedge clk); #1;
    end
    rr = 1'b0; rv = 1'b1; ra = 7'd20;
    @(posedge clk); #1;
    rv = 1'b0;
    n = 0;
    while (!(val[0] && val[1]) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chkb("post_rst_rsp0", val[0], 1'b1);
    chkb("post_rst_rsp1", val[1], 1'b1);
    chkd("post_rst_data0", dat[0], mem[20]);
    chkd("post_rst_data1", dat[1], mem[20]);
    @(posedge clk); #1;
    rr = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic until each controller has accepted 1000 requests.
    a0 = u[0].acc; a1 = u[1].acc; n = 0;
    while ((u[0].acc < a0 + 1000 || u[1].acc < a1 + 1000) && n < 20000) begin
      rv = 1'($urandom_range(0, 1));
      ra = 7'($urandom_range(0, 127));
      rr = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chkb("random_completed", (u[0].acc >= a0 + 1000) && (u[1].acc >= a1 + 1000), 1'b1);

    rv = 1'b0; rr = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chkb("drain_empty0", u[0].qsz == 0, 1'b1);
    chkb("drain_empty1", u[1].qsz == 0, 1'b1);
    chkb("drain_valid0", val[0], 1'b0);
    chkb("drain_valid1", val[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
